// File: rtl/sram_param_pkg.sv
// +--------------------------------------------------------------------------+
// | sram_param_pkg : shared types and helpers for the parametrised 1RW1R SRAM |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package sram_param_pkg;

  localparam int c_MAX_DATA_W = 1024;
  localparam int c_MAX_LANE_W = 64;

  typedef logic [c_MAX_DATA_W-1:0] wide_t;
  typedef logic [c_MAX_LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Even parity of one lane; zero-extension of narrower lanes leaves it unchanged.
  function automatic logic lane_parity(input lane_t lane);
    return ^lane;
  endfunction

  function automatic wide_t lane_merge(input wide_t old_w, input wide_t new_w,
                                       input wide_t bit_mask);
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_clear_seq.sv
// +--------------------------------------------------------------------------+
// | sram_clear_seq : reset/clear/ready FSM with the clear-sweep address       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_clear_seq
  import sram_param_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    clr_we      = 1'b0;
    ready       = 1'b0;
    case (r_state)
      ST_RESET: w_state_nxt = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (r_clr_addr == c_LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: ready = 1'b1;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  assign clr_addr = r_clr_addr;

endmodule

`default_nettype wire

// File: rtl/sram_1rw1r_param.sv
// +--------------------------------------------------------------------------+
// | sram_1rw1r_param : parametrised 1RW1R SRAM, lane write mask, reset clear  |
// | Optional lane parity enabled by defining SRAM_PARITY_EN.                  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_1rw1r_param
  import sram_param_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    LANE_WIDTH    = 8,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               csb0,
  input  logic                               web0,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  input  logic [DATA_WIDTH-1:0]              din0,
  output logic [DATA_WIDTH-1:0]              dout0,
  output logic                               rvalid0,
  input  logic                               csb1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  output logic [DATA_WIDTH-1:0]              dout1,
  output logic                               rvalid1,
  output logic                               ready,
  output logic                               perr0,
  output logic                               perr1
);

  localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_bit_mask;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_mem_din;
  logic [DATA_WIDTH-1:0] w_rd_word0;
  logic [DATA_WIDTH-1:0] w_rd_word1;
  logic                  w_perr0;
  logic                  w_perr1;

  sram_clear_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr0  = rst_n & ready & ~csb0 & ~web0;
  assign w_rd0  = rst_n & ready & ~csb0 &  web0;
  assign w_rd1  = rst_n & ready & ~csb1;
  assign w_coll = w_wr0 & w_rd1 & (addr0 == addr1);

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_mask
    assign w_bit_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
  end

  // Lane merge is done as read-modify-write so the same word can be forwarded on a collision.
  assign w_wr_data  = DATA_WIDTH'(lane_merge(wide_t'(r_mem[addr0]), wide_t'(din0),
                                             wide_t'(w_bit_mask)));
  assign w_mem_we   = rst_n & (w_clr_we | w_wr0);
  assign w_mem_addr = w_clr_we ? w_clr_addr : addr0;
  assign w_mem_din  = w_clr_we ? CLEAR_VALUE : w_wr_data;
  assign w_rd_word0 = r_mem[addr0];
  assign w_rd_word1 = w_coll ? w_wr_data : r_mem[addr1];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] r_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_din_par;
  logic [NUM_WMASKS-1:0] w_clr_par;
  logic [NUM_WMASKS-1:0] w_wr_par;
  logic [NUM_WMASKS-1:0] w_chk_par0;
  logic [NUM_WMASKS-1:0] w_chk_par1;
  logic [NUM_WMASKS-1:0] w_rd_par1;

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_par
    assign w_din_par[i]  = lane_parity(lane_t'(din0[i*LANE_WIDTH +: LANE_WIDTH]));
    assign w_clr_par[i]  = lane_parity(lane_t'(CLEAR_VALUE[i*LANE_WIDTH +: LANE_WIDTH]));
    assign w_chk_par0[i] = lane_parity(lane_t'(w_rd_word0[i*LANE_WIDTH +: LANE_WIDTH]));
    assign w_chk_par1[i] = lane_parity(lane_t'(w_rd_word1[i*LANE_WIDTH +: LANE_WIDTH]));
  end

  assign w_wr_par  = (w_din_par & wmask0) | (r_par[addr0] & ~wmask0);
  assign w_rd_par1 = w_coll ? w_wr_par : r_par[addr1];
  assign w_perr0   = |(w_chk_par0 ^ r_par[addr0]);
  assign w_perr1   = |(w_chk_par1 ^ w_rd_par1);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_clr_we ? w_clr_par : w_wr_par;
    end
  end
`else
  assign w_perr0 = 1'b0;
  assign w_perr1 = 1'b0;
`endif

  // dout holds between reads; rvalid/perr only pulse for the cycle of a read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout0   <= '0;
      dout1   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      perr0   <= 1'b0;
      perr1   <= 1'b0;
    end else begin
      rvalid0 <= w_rd0;
      rvalid1 <= w_rd1;
      perr0   <= w_rd0 & w_perr0;
      perr1   <= w_rd1 & w_perr1;
      if (w_rd0) begin
        dout0 <= w_rd_word0;
      end
      if (w_rd1) begin
        dout1 <= w_rd_word1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
// +--------------------------------------------------------------------------+
// | tb_sram_1rw1r_param : directed self-checking bench for sram_1rw1r_param  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sram_1rw1r_param;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          csb0, web0, csb1;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0, dout1;
  logic          rvalid0, rvalid1, ready, perr0, perr1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mdl [16];
  logic [DW-1:0] exp0, exp1;
  int            cnt;

  sram_1rw1r_param #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .LANE_WIDTH    (8),
    .INIT_ON_RESET (1),
    .CLEAR_VALUE   (32'h0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .csb0    (csb0),
    .web0    (web0),
    .wmask0  (wmask0),
    .addr0   (addr0),
    .din0    (din0),
    .dout0   (dout0),
    .rvalid0 (rvalid0),
    .csb1    (csb1),
    .addr1   (addr1),
    .dout1   (dout1),
    .rvalid1 (rvalid1),
    .ready   (ready),
    .perr0   (perr0),
    .perr1   (perr1)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts post-edge samples with ready low, starting from the release edge.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) break;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = 4'h0; addr0 = '0; addr1 = '0; din0 = '0;
    tick(); tick();
    chk_eq("rst_ready", 32'(ready), 32'd0);
    chk_eq("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk_eq("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk_eq("rst_dout0", dout0, 32'h0);
    chk_eq("rst_dout1", dout1, 32'h0);
    chk_eq("rst_perr", 32'({perr0, perr1}), 32'd0);

    rst_n = 1'b1;
    wait_ready(cnt);
    chk_eq("clear_len", 32'(cnt), 32'd16);

    // Whole array reads back as cleared
    csb1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr1 = AW'(i);
      tick();
      chk_eq("clr_dout1", dout1, 32'h0);
      chk_eq("clr_rvalid1", 32'(rvalid1), 32'd1);
    end
    csb1 = 1'b1;
    tick();
    chk_eq("idle_rvalid1", 32'(rvalid1), 32'd0);

    // Lane-masked writes
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'h3; din0 = 32'hAABBCCDD; wmask0 = 4'hF;
    tick();
    chk_eq("wr_rvalid0", 32'(rvalid0), 32'd0);
    din0 = 32'h11223344; wmask0 = 4'h5;
    tick();
    din0 = 32'hFFFFFFFF; wmask0 = 4'h0;
    tick();
    web0 = 1'b1;
    tick();
    chk_eq("mask_merge", dout0, 32'hAA22CC44);
    chk_eq("mask_rvalid0", 32'(rvalid0), 32'd1);

    // Write-first collision
    web0 = 1'b0; addr0 = 4'h7; din0 = 32'hDEADBEEF; wmask0 = 4'h3;
    csb1 = 1'b0; addr1 = 4'h7;
    tick();
    chk_eq("coll_dout1", dout1, 32'h0000BEEF);
    chk_eq("coll_rvalid1", 32'(rvalid1), 32'd1);
    chk_eq("coll_rvalid0", 32'(rvalid0), 32'd0);
    web0 = 1'b1; csb1 = 1'b1;
    tick();
    chk_eq("coll_dout0", dout0, 32'h0000BEEF);
    csb0 = 1'b1;
    tick();
    chk_eq("hold_dout0", dout0, 32'h0000BEEF);
    chk_eq("hold_rvalid0", 32'(rvalid0), 32'd0);

    // Fill with distinct patterns
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
    for (int i = 0; i < 16; i++) begin
      addr0 = AW'(i);
      din0  = (32'h01010101 * i) ^ 32'hA5A50000;
      mdl[i] = din0;
      tick();
    end
    web0 = 1'b1; csb0 = 1'b1;
    exp0 = dout0; exp1 = dout1;

    // Mixed read/idle traffic on both ports
    for (int k = 0; k < 64; k++) begin
      logic rd0, rd1;
      rd0 = (k % 3) != 2;
      rd1 = (k % 4) != 3;
      csb0 = ~rd0; addr0 = AW'(k);
      csb1 = ~rd1; addr1 = AW'(k * 5 + 3);
      tick();
      if (rd0) exp0 = mdl[addr0];
      if (rd1) exp1 = mdl[addr1];
      chk_eq("mix_dout0", dout0, exp0);
      chk_eq("mix_rvalid0", 32'(rvalid0), 32'(rd0));
      chk_eq("mix_dout1", dout1, exp1);
      chk_eq("mix_rvalid1", 32'(rvalid1), 32'(rd1));
      chk_eq("mix_perr", 32'({perr0, perr1}), 32'd0);
    end
    csb0 = 1'b1; csb1 = 1'b1;
    tick();

`ifdef SRAM_PARITY_EN
    dut.r_mem[2][9] = ~dut.r_mem[2][9];
    csb1 = 1'b0; addr1 = 4'h2;
    tick();
    chk_eq("par_bad_perr1", 32'(perr1), 32'd1);
    chk_eq("par_bad_rvalid1", 32'(rvalid1), 32'd1);
    addr1 = 4'h4;
    tick();
    chk_eq("par_good_perr1", 32'(perr1), 32'd0);
    csb1 = 1'b1;
    tick();
    chk_eq("par_idle_perr1", 32'(perr1), 32'd0);
`else
    csb1 = 1'b0; addr1 = 4'h2;
    tick();
    chk_eq("nopar_perr1", 32'(perr1), 32'd0);
    chk_eq("nopar_dout1", dout1, mdl[2]);
    csb1 = 1'b1;
    tick();
`endif

    // Reset mid-sweep with writes and reads pending
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'h5; din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 4'h5;
    rst_n = 1'b0;
    tick();
    chk_eq("rst2_ready", 32'(ready), 32'd0);
    chk_eq("rst2_rvalid1", 32'(rvalid1), 32'd0);
    chk_eq("rst2_dout1", dout1, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_eq("sweep_ready", 32'(ready), 32'd0);
      chk_eq("sweep_rvalid1", 32'(rvalid1), 32'd0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(cnt);
    chk_eq("reclear_len", 32'(cnt), 32'd16);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    tick();
    chk_eq("post_rvalid0", 32'(rvalid0), 32'd0);

    // Sweep restarted from 0 and covered every word; pending writes were ignored
    csb0 = 1'b0; csb1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr0 = AW'(i);
      addr1 = AW'(15 - i);
      tick();
      chk_eq("reclr_dout0", dout0, 32'h0);
      chk_eq("reclr_dout1", dout1, 32'h0);
      chk_eq("reclr_rvalid", 32'({rvalid0, rvalid1}), 32'd3);
    end
    csb0 = 1'b1; csb1 = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
